// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset vector and fetch state encoding
package fetch_pkg;
  localparam int ADDR_W = 11;
  localparam int INSTR_W = 16;
  localparam int STACK_DEPTH = 16;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 11'h000;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_unit_call_stack.sv
// call_stack: LIFO of return addresses with full/empty flags
module call_stack #(
  parameter int DEPTH = 16,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int IW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [IW:0] ptr;
  logic [IW-1:0] top_idx;
  assign top_idx = ptr[IW-1:0] - IW'(1);
  assign top = mem[top_idx];
  assign full = ptr == (IW+1)'(DEPTH);
  assign empty = ptr == '0;
  // reset only empties the pointer; stored entries are left as they are
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (push && !full) begin
      mem[ptr[IW-1:0]] <= push_data;
      ptr <= ptr + 1'b1;
    end else if (pop && !empty) ptr <= ptr - 1'b1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-address select and return stack for the instruction memory
module fetch_unit #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int STACK_DEPTH = fetch_pkg::STACK_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               halt,
  input  logic               jump,
  input  logic               call,
  input  logic               ret,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  address,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               stack_err,
  output logic               halted
);
  import fetch_pkg::*;
  fetch_state_t state;
  logic [ADDR_W-1:0] pc, pc_inc, next_pc, top;
  logic run, push, pop, full, empty;
  assign run = state == RUN && !halt && !stall;
  assign pc_inc = pc + ADDR_W'(1);
  assign push = run && call && !ret;
  assign pop = run && ret;
  // redirect priority: stall, ret (falls through when empty), call/jump, sequential
  always_comb next_pc = stall ? pc : ret ? (empty ? pc_inc : top) : (call || jump) ? jump_addr : pc_inc;
  // address is combinational so redirects cost no bubble; halt freezes it at pc
  always_comb address = (rst || state == BOOT) ? RESET_VECTOR : (state == HALT || halt) ? pc : next_pc;
  assign instr_out = instruction_in;
  assign instr_pc = pc;
  assign instr_valid = state == RUN;
  assign halted = state == HALT;
  call_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .push_data(pc_inc),
    .top(top),
    .full(full),
    .empty(empty)
  );
  // state machine, PC tracking the issued address, sticky stack error
  always_ff @(posedge clk)
    if (rst) begin
      state <= BOOT;
      pc <= RESET_VECTOR;
      stack_err <= 1'b0;
    end else begin
      state <= (state == BOOT) ? RUN : (state == RUN && halt) ? HALT : state;
      pc <= address;
      stack_err <= stack_err || (push && full) || (pop && empty);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed fetch stimulus against a queue-based reference model
module tb_fetch_unit;
  typedef struct {
    logic [10:0] addr;
    logic        valid;
    logic        halted;
    logic        err;
    logic [10:0] pc;
  } exp_t;
  logic clk = 1'b0;
  logic rst, stall, halt, jump, call, ret;
  logic [10:0] jump_addr, address, instr_pc;
  logic [15:0] instruction_in, instr_out;
  logic instr_valid, stack_err, halted;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  exp_t e;
  int m_state;
  logic [10:0] m_pc;
  logic [10:0] stk[$];
  logic m_err;
  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .jump(jump), .call(call), .ret(ret),
    .jump_addr(jump_addr), .address(address), .instruction_in(instruction_in), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .stack_err(stack_err), .halted(halted)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] ins_of(input logic [10:0] a);
    return {5'b10110, a} ^ 16'h3c5a;
  endfunction
  always @(posedge clk) instruction_in <= ins_of(address);
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("address", 32'(address), 32'(e.addr));
      chk("instr_valid", 32'(instr_valid), 32'(e.valid));
      chk("halted", 32'(halted), 32'(e.halted));
      chk("stack_err", 32'(stack_err), 32'(e.err));
      chk("instr_pc", 32'(instr_pc), 32'(e.pc));
      if (e.valid) chk("instr_out", 32'(instr_out), 32'(ins_of(e.pc)));
    end
  task automatic cyc(input logic r, s, h, j, c, rt, input logic [10:0] ja);
    logic [10:0] a;
    rst = r; stall = s; halt = h; jump = j; call = c; ret = rt; jump_addr = ja;
    if (r || m_state == 0) a = 11'h000;
    else if (m_state == 2 || h || s) a = m_pc;
    else if (rt) a = (stk.size() != 0) ? stk[$] : m_pc + 11'd1;
    else if (c || j) a = ja;
    else a = m_pc + 11'd1;
    sb.push_back('{addr: a, valid: m_state == 1, halted: m_state == 2, err: m_err, pc: m_pc});
    @(posedge clk);
    if (r) begin
      m_state = 0; stk.delete(); m_err = 1'b0;
    end else if (m_state == 0) m_state = 1;
    else if (m_state == 1) begin
      if (h) m_state = 2;
      else if (!s && rt) begin
        if (stk.size() == 0) m_err = 1'b1;
        else void'(stk.pop_back());
      end else if (!s && c) begin
        if (stk.size() == 16) m_err = 1'b1;
        else stk.push_back(m_pc + 11'd1);
      end
    end
    m_pc = r ? 11'h000 : a;
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 11'h0);
  endtask
  task automatic go(input logic [10:0] a);
    cyc(0, 0, 0, 1, 0, 0, a);
  endtask
  task automatic reset3();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 11'h0);
  endtask
  initial begin
    rst = 1'b1; stall = 0; halt = 0; jump = 0; call = 0; ret = 0; jump_addr = '0;
    m_state = 0; m_pc = 11'h000; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset3();
    idle(6);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0, 0, 11'h3ff);
    cyc(0, 0, 0, 1, 0, 0, 11'h100);
    idle(2);
    go(11'h010);
    cyc(0, 0, 0, 0, 1, 0, 11'h200);
    idle(3);
    cyc(0, 0, 0, 0, 0, 1, 11'h0);
    idle(2);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 11'(11'h300 + i * 8));
      idle(1);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 11'h0);
      idle(1);
    end
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, 1, 0, 11'(11'h500 + i * 4));
    idle(1);
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, 0, 1, 11'h0);
    reset3();
    idle(1);
    go(11'h007);
    cyc(0, 0, 0, 0, 0, 1, 11'h0);
    idle(2);
    go(11'h7fe);
    idle(3);
    go(11'h7ff);
    cyc(0, 0, 0, 0, 1, 0, 11'h123);
    idle(1);
    cyc(0, 0, 0, 0, 0, 1, 11'h0);
    idle(1);
    reset3();
    idle(1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 11'(11'h080 + i * 16));
    go(11'h040);
    cyc(0, 0, 1, 0, 0, 0, 11'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 11'h222);
    reset3();
    idle(3);
    cyc(0, 0, 0, 0, 0, 1, 11'h0);
    for (int i = 0; i < 400; i++) begin
      logic r, s, h, j, c, rt;
      r = (m_state == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 49) == 0);
      s = $urandom_range(0, 4) == 0;
      h = $urandom_range(0, 79) == 0;
      j = $urandom_range(0, 7) == 0;
      c = $urandom_range(0, 5) == 0;
      rt = $urandom_range(0, 5) == 0;
      cyc(r, s, h, j, c, rt, 11'($urandom));
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch stage for the Natalius core. It drives the address of the synchronous 2048×16 instruction memory and tracks which PC the returned instruction belongs to. It handles sequential fetch, stalls, jumps, and call/return through an internal return-address stack. The memory has a one-cycle read latency, so the address is computed combinationally for the next cycle and redirects cost zero bubbles.

## Interface
Parameters:
- ADDR_W, 11, instruction address width (2048 words)
- INSTR_W, 16, instruction width
- STACK_DEPTH, 16, return-stack entries (power of two)
- RESET_VECTOR, 11'h000, first fetched address

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold the current instruction; no PC advance
- halt  in  1  enter HALT (exit only by rst)
- jump  in  1  redirect to jump_addr
- call  in  1  push return address, redirect to jump_addr
- ret  in  1  pop return address, redirect to it
- jump_addr  in  ADDR_W  target for jump/call
- address  out  ADDR_W  to the instruction memory address port (combinational)
- instruction_in  in  INSTR_W  from the instruction memory data output
- instr_out  out  INSTR_W  equals instruction_in (pass-through)
- instr_pc  out  ADDR_W  PC of instr_out
- instr_valid  out  1  instr_out is a real instruction for instr_pc
- stack_err  out  1  sticky overflow/underflow flag
- halted  out  1  high in HALT

## Operation
- Registers:
  - pc: the address issued last cycle, which is the PC of the current instruction_in.
  - state: one of BOOT, RUN, HALT.
  - Stack pointer and stack memory.
- BOOT
  - Entered on rst.
  - address = RESET_VECTOR, instr_valid = 0.
  - Moves to RUN on the first edge with rst low.
- RUN
  - instr_valid = 1.
  - The next address is selected by the first matching condition, highest priority first:
    1. stall: pc.
    2. ret: top of stack.
    3. call: jump_addr, and push pc+1.
    4. jump: jump_addr.
    5. Otherwise: pc+1.
  - On every edge in RUN, pc <= address.
- Stall dominance: redirects presented with stall are ignored. Control reasserts them next cycle because the instruction is held.
- Multiple redirects asserted together resolve by the priority above. Only one stack operation happens per cycle.
- Address arithmetic is modulo 2^ADDR_W, so pc = 2047 sequentially wraps to 0. A call at pc = 2047 pushes 0.
- Stack overflow: a call with the stack full still redirects, the push is dropped, and stack_err is set.
- Stack underflow: a ret with the stack empty falls through to pc+1, and stack_err is set.
- stack_err stays set until rst.
- HALT
  - Entered from RUN when halt is asserted; halt takes priority over all other inputs.
  - address = pc, instr_valid = 0, halted = 1.
  - Redirect and stall inputs are ignored.
- Inputs in BOOT and HALT are ignored except rst.
- Reset values:
  - state = BOOT, pc = RESET_VECTOR.
  - Stack pointer = 0 (empty), stack_err = 0.
  - instr_valid = 0, halted = 0, instr_pc = RESET_VECTOR.
  - address = RESET_VECTOR while rst is high.
- Reset mid-operation: the stack is emptied and the PC returns to RESET_VECTOR on the same edge. Stack contents are not cleared, only the pointer.

## Timing
- Address is presented in cycle n; instruction_in for that address is valid in cycle n+1.
- instr_pc = pc, so it is always aligned with instruction_in.
- BOOT lasts one cycle after rst falls. The instruction at RESET_VECTOR is valid on the second cycle after rst deasserts (first RUN cycle).
- Jump, call and ret take effect with zero bubbles: the target instruction appears in the cycle after the redirect is sampled.
- Stall holds instr_out and instr_pc stable for every stalled cycle, and the memory re-reads the same address.
- The push or pop commits on the same edge as the redirect. The stack top is readable combinationally for ret.
- There is no combinational path from instruction_in to address.

## Structure
- Shared package fetch_pkg:
  - ADDR_W, INSTR_W, RESET_VECTOR.
  - State enum fetch_state_t {BOOT, RUN, HALT}.
- Sub-module call_stack:
  - LIFO of STACK_DEPTH × ADDR_W.
  - Ports: push, pop, push_data, top, full, empty.
  - Pointer width is clog2(STACK_DEPTH)+1.
- fetch_unit holds the state machine, the PC register, the next-address mux and the sticky error flag.

## Test plan
- Reset/boot: rst high 3 cycles, then low.
  - address = 0 throughout.
  - instr_valid = 0 for one cycle, then 1 with instr_pc = 0.
  - instr_pc then increments 1, 2, 3 each cycle.
- Stall and jump: stall for 3 cycles at pc = 5 with jump asserted.
  - instr_pc stays 5 and the jump is ignored.
  - Release stall with jump to 0x100: the next instr_pc is 0x100.
- Call/return: call to 0x200 at pc = 0x010, then ret at pc = 0x203.
  - The sequence is 0x010, 0x200..0x203, then 0x011.
  - Nested to depth 16 and fully unwound in order, with stack_err = 0.
- Overflow/underflow:
  - The 17th nested call still redirects and sets stack_err; the 16 stored returns are intact.
  - After reset, a ret at pc = 7 goes to 8 and sets stack_err.
- Wrap: sequential fetch from pc = 2046 gives 2047 then 0. A call at 2047 pushes 0 and the matching ret returns to 0.
- Halt and reset mid-run: halt at pc = 0x040 gives halted = 1 and instr_valid = 0, with address held at 0x040 and jumps ignored. A following rst with the stack at depth 3 gives an empty stack and restarts from 0.
